// File: rtl/alu_arbiter.sv
// Two-requester arbiter for the shared execute-stage ALU, with a one-entry registered result stage.
// Define ALU_ARBITER_PERF_EN to add the perf_grant0/perf_grant1/perf_stall counters.
module alu_arbiter #(
    parameter int DataWidth   = 32,
    parameter int StarveLimit = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [3:0]           req0_alu_control,
    input  logic [DataWidth-1:0] req0_operand_a,
    input  logic [DataWidth-1:0] req0_operand_b,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [3:0]           req1_alu_control,
    input  logic [DataWidth-1:0] req1_operand_a,
    input  logic [DataWidth-1:0] req1_operand_b,

    output logic [3:0]           alu_control,
    output logic [DataWidth-1:0] alu_operand_a,
    output logic [DataWidth-1:0] alu_operand_b,
    input  logic [DataWidth-1:0] alu_result,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [DataWidth-1:0] rsp_data
`ifdef ALU_ARBITER_PERF_EN
    ,
    output logic [31:0]          perf_grant0,
    output logic [31:0]          perf_grant1,
    output logic [31:0]          perf_stall
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [3:0] StarveThresh = 4'(StarveLimit);

    state_t     state;
    logic [3:0] starveCount;
    logic       canAccept;
    logic       grantValid;
    logic       grantId;
    logic       accept;

    // Starvation override first, then fixed priority with requester 0 ahead of requester 1.
    always_comb begin
        grantValid = 1'b0;
        grantId    = 1'b0;
        if (req1_valid && (starveCount >= StarveThresh)) begin
            grantValid = 1'b1;
            grantId    = 1'b1;
        end else if (req0_valid) begin
            grantValid = 1'b1;
            grantId    = 1'b0;
        end else if (req1_valid) begin
            grantValid = 1'b1;
            grantId    = 1'b1;
        end
    end

    assign canAccept  = !flush && ((state == EMPTY) || rsp_ready);
    assign accept     = canAccept && grantValid;
    assign req0_ready = accept && !grantId;
    assign req1_ready = accept && grantId;
    assign rsp_valid  = (state == FULL);

    // The ALU sees the granted operation even while the result stage is stalled.
    always_comb begin
        alu_control   = '0;
        alu_operand_a = '0;
        alu_operand_b = '0;
        if (grantValid) begin
            if (grantId) begin
                alu_control   = req1_alu_control;
                alu_operand_a = req1_operand_a;
                alu_operand_b = req1_operand_b;
            end else begin
                alu_control   = req0_alu_control;
                alu_operand_a = req0_operand_a;
                alu_operand_b = req0_operand_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state    <= FULL;
                        rsp_id   <= grantId;
                        rsp_data <= alu_result;
                    end
                end
                FULL: begin
                    // Flush discards the held result even if it is being drained this cycle.
                    if (flush) begin
                        state <= EMPTY;
                    end else if (accept) begin
                        rsp_id   <= grantId;
                        rsp_data <= alu_result;
                    end else if (rsp_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starveCount <= 4'd0;
        end else if (flush) begin
            starveCount <= 4'd0;
        end else if (req1_valid && !req1_ready) begin
            if (starveCount != 4'hF) begin
                starveCount <= starveCount + 4'd1;
            end
        end else begin
            starveCount <= 4'd0;
        end
    end

`ifdef ALU_ARBITER_PERF_EN
    // Counters ignore flush so they reflect every cycle the arbiter saw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant0 <= 32'd0;
            perf_grant1 <= 32'd0;
            perf_stall  <= 32'd0;
        end else begin
            if (req0_valid && req0_ready) begin
                perf_grant0 <= perf_grant0 + 32'd1;
            end
            if (req1_valid && req1_ready) begin
                perf_grant1 <= perf_grant1 + 32'd1;
            end
            if ((req0_valid || req1_valid) && !accept) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

    assert property (@(posedge clk) disable iff (!rst_n) !(req0_ready && req1_ready));
    assert property (@(posedge clk) disable iff (!rst_n) flush |-> !(req0_ready || req1_ready));

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single execute-stage ALU (4-bit alu_control, two DataWidth operands, combinational result) between two requesters:
  - requester 0: main pipeline issue;
  - requester 1: auxiliary address-generation / CSR path.
- Arbitrates with fixed priority plus starvation protection.
- Drives the ALU inputs and captures the result into a one-entry registered output with a valid/ready handshake toward the writeback/memory stage.

Parameters:
- DataWidth, 32, operand/result width.
- StarveLimit, 4, consecutive denied cycles of req1 before req1 gets priority (legal range 1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_alu_control  input  4  requester 0 ALU opcode.
- req0_operand_a  input  DataWidth  requester 0 operand A.
- req0_operand_b  input  DataWidth  requester 0 operand B.
- req1_valid, req1_ready, req1_alu_control, req1_operand_a, req1_operand_b: same as requester 0, for requester 1.
- alu_control  output  4  to ALU.
- alu_operand_a  output  DataWidth  to ALU.
- alu_operand_b  output  DataWidth  to ALU.
- alu_result  input  DataWidth  from ALU, combinational.
- rsp_valid  output  1  result register holds data.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  1  requester that owns rsp_data.
- rsp_data  output  DataWidth  captured ALU result.

Behaviour:
- Reset is asynchronous on rst_n low: rsp_valid=0, rsp_id=0, rsp_data=0, starve counter=0, state=EMPTY. Perf counters are also cleared when present.
- FSM has two states, EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = !flush && (EMPTY || rsp_ready).
- Grant selection:
  - If req1_valid and starve counter >= StarveLimit: grant req1.
  - Else if req0_valid: grant req0.
  - Else if req1_valid: grant req1.
  - Else: no grant.
- reqN_ready = can_accept && grant==N. Ready is combinational, and at most one ready is high per cycle.
- ALU drive:
  - When a grant exists, alu_control/alu_operand_a/alu_operand_b equal the granted requester's fields, independent of can_accept.
  - With no grant, all three are 0.
- Handshake (reqN_valid && reqN_ready) at edge k:
  - rsp_data <= alu_result, rsp_id <= N, rsp_valid <= 1 at edge k.
  - Result is visible the cycle after acceptance: 1-cycle latency.
- Drain:
  - rsp_valid && rsp_ready with no new handshake: rsp_valid <= 0 (FULL->EMPTY).
  - Drain and new handshake in the same cycle: stays FULL with the new data. Zero-bubble throughput, one op per cycle.
- Backpressure: FULL && !rsp_ready holds rsp_data/rsp_id stable, and both readys are 0.
- Starve counter (4-bit, saturating at 15):
  - Increments when req1_valid && !req1_ready.
  - Clears on a req1 handshake or when req1_valid=0.
- flush:
  - rsp_valid <= 0; rsp_data/rsp_id keep their values.
  - Starve counter <= 0.
  - No handshake that cycle: readys are 0.
  - Flush overrides a simultaneous rsp_ready drain; the drained result is treated as discarded.
- Requesters hold fields stable while valid and not ready. The arbiter does not enforce this.
- rst_n asserted mid-operation: in-flight result lost, outputs return to reset values immediately.

Optional Feature:
- Macro ALU_ARBITER_PERF_EN.
- When defined, adds outputs perf_grant0 [31:0], perf_grant1 [31:0] and perf_stall [31:0]:
  - perf_grant0/perf_grant1 count handshakes per requester.
  - perf_stall counts cycles with any reqN_valid and no handshake.
  - All counters wrap modulo 2^32, reset to 0 on rst_n, and are unaffected by flush.
- When undefined, these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset then single op:
  - Stimulus: release rst_n; req0 {ctl=ADD, a=5, b=7} with model ALU, rsp_ready=1.
  - Required: req0_ready=1 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=12; one cycle later rsp_valid=0.
- Back-to-back throughput:
  - Stimulus: req0 issues 8 consecutive ops, rsp_ready=1 throughout.
  - Required: 8 consecutive rsp_valid cycles, no bubbles, data in order.
- Starvation:
  - Stimulus: req0 and req1 valid continuously, StarveLimit=4, rsp_ready=1.
  - Required: req0 granted cycles 0-3, req1 granted cycle 4, then req0 resumes; pattern repeats every 5 cycles.
- Backpressure:
  - Stimulus: rsp_ready=0 for 3 cycles with rsp_valid=1, req0_valid=1.
  - Required: both readys=0; rsp_data stable; on rsp_ready=1, drain and new accept occur in the same cycle.
- Flush with simultaneous activity:
  - Stimulus: flush=1 while FULL, rsp_ready=1, req0_valid=1.
  - Required: readys=0; next cycle rsp_valid=0; starve counter=0.
- Async reset mid-op:
  - Stimulus: drop rst_n between clock edges while FULL.
  - Required: rsp_valid=0 immediately, before the next clk edge. Perf counters (if ALU_ARBITER_PERF_EN) read 0.
